proc_step_ctrl: RTL and testbench
=================================

# proc_step_ctrl

Execution controller for the multicycle processor. Converts the debounced KEY strobe and mode switches into a registered one-cycle clock-enable that sequences the processor in cycle-step, instruction-step, free-run or run-to-breakpoint mode. Sits between the KeyFilter output and the processor's enable input, and observes the processor's PC and current-state outputs. Drives status for LEDs and a 16-bit enable counter for the HEX mux.

## Interface
- RUN_DIV, 25_000_000, clk cycles between enables in run modes (≥2); benches use 4
- FETCH_STATE, 4'd1, processor state code marking the start of an instruction
- STEP_LIMIT, 16, maximum enables per instruction-step before abort
- clk  in  1  system clock (CLOCK_50 domain)
- Reset  in  1  asynchronous, active-high; one clock, no other clock domains
- StepPulse  in  1  single-cycle strobe from KeyFilter
- Mode  in  2  00 cycle-step, 01 instruction-step, 10 run, 11 run-to-break
- BreakPC  in  7  breakpoint address
- PC_In  in  7  processor PC
- State_In  in  4  processor current state
- ProcEn  out  1  registered one-cycle enable to processor
- Busy  out  1  high in any state other than IDLE and BREAK
- BreakHit  out  1  sticky; high while in BREAK
- Timeout  out  1  sticky; set on instruction-step abort, cleared by next accepted StepPulse or Reset
- CycleCount  out  16  number of ProcEn pulses issued

## Operation
- States: IDLE, ISSUE, CHECK, RUN, BREAK.
- IDLE
  - Mode[1]=1 → RUN, with divider=0 and armed=0.
  - Mode=00 with StepPulse → ISSUE, single issue.
  - Mode=01 with StepPulse → ISSUE, instruction issue, with the enable count cleared.
  - Mode is sampled only in IDLE.
- ISSUE: ProcEn=1 for exactly this cycle.
  - Single issue → IDLE.
  - Instruction issue → CHECK; the enable count increments.
- CHECK: the processor has updated, so State_In is valid.
  - State_In==FETCH_STATE → IDLE.
  - Else, enable count==STEP_LIMIT → IDLE and set Timeout.
  - Else → ISSUE.
- RUN
  - The divider counts 0..RUN_DIV-1. ProcEn=1 in the cycle the divider equals RUN_DIV-1; the divider then wraps to 0.
  - Mode[1]=0 observed in RUN → IDLE next cycle, with no ProcEn that cycle even if the divider is at terminal.
  - Mode=11 and armed=1: in the cycle after any ProcEn, if PC_In==BreakPC and State_In==FETCH_STATE → BREAK, set BreakHit.
  - armed sets after the first ProcEn in RUN, so resuming from a breakpoint does not re-trigger on the same PC.
- BREAK: no enables.
  - StepPulse → IDLE, clear BreakHit.
  - Mode≠11 → IDLE, clear BreakHit.
- StepPulse outside IDLE/BREAK is ignored, not queued.
- CycleCount increments on every ProcEn and wraps 0xFFFF→0x0000.
- Breakpoint compare is exact 7-bit equality.

## Timing
- Reset (asynchronous, any state): state IDLE; ProcEn, Busy, BreakHit, Timeout=0; CycleCount=0; divider=0; armed=0.
- Reset mid-instruction-step or mid-run returns to IDLE immediately. No partial ProcEn pulse is emitted after Reset deasserts.
- Step latency: StepPulse at cycle n → ProcEn at n+1. Busy is high during n+1 only (cycle-step).
- Instruction-step: ProcEn is high every other cycle (ISSUE/CHECK alternate). An instruction needing k enables finishes in IDLE at cycle n+2k+1.
- Run: first ProcEn RUN_DIV cycles after entering RUN. Subsequent pulses are spaced exactly RUN_DIV cycles apart.
- Breakpoint: detected in the cycle after ProcEn. BREAK and BreakHit are visible the following cycle. At most one extra divider cycle elapses, and no further ProcEn is issued.
- StepPulse coincident with a Mode change in IDLE: Mode as sampled that cycle decides.
- All outputs are registered.

## Test plan
- Reset then Mode=00, three StepPulses spaced 5 cycles → three single-cycle ProcEn, each one cycle after its strobe. CycleCount=3.
- Mode=01; model processor visits states 1→2→3→1 → exactly three ProcEn, alternating with check cycles. Return to IDLE on seeing state 1. Timeout=0.
- Mode=01 with State_In stuck at 2 → exactly 16 ProcEn, then IDLE with Timeout=1. The next StepPulse clears Timeout.
- Mode=10, RUN_DIV=4 → ProcEn every 4th cycle. Switching Mode to 00 at a divider terminal cycle → no pulse that cycle, IDLE next cycle.
- Mode=11, BreakPC=7'h05, PC increments per instruction → BREAK when PC_In=05 at fetch, BreakHit=1, ProcEn stays 0. StepPulse → resume running with no immediate re-break at PC 05.
- CycleCount preset path: run 65536 enables → count wraps to 0x0000. Assert Reset mid-RUN → all outputs 0 asynchronously.

Source files
------------

// File: rtl/proc_step_ctrl.sv
// proc_step_ctrl
// Execution controller for the multicycle processor. Turns the debounced KEY
// strobe and the mode switches into a registered one-cycle enable. The four
// modes are cycle-step, instruction-step, free-run and run-to-breakpoint. It
// also produces LED status and a 16-bit enable counter for the HEX mux.
//
// Ports
//   clk         system clock (CLOCK_50 domain)
//   Reset       asynchronous, active-high
//   StepPulse   single-cycle strobe from KeyFilter
//   Mode        00 cycle-step, 01 instruction-step, 10 run, 11 run-to-break
//   BreakPC     breakpoint address (exact 7-bit compare)
//   PC_In       processor PC
//   State_In    processor current state
//   ProcEn      registered one-cycle enable to the processor
//   Busy        high in ISSUE, CHECK and RUN
//   BreakHit    sticky, high while in BREAK
//   Timeout     sticky, set on instruction-step abort
//   CycleCount  number of ProcEn pulses issued (wraps)
//
// CYCLE_PRESET is the reset value of CycleCount. It defaults to zero and
// exists so that the wrap path can be reached without 64K enables.
module proc_step_ctrl #(
  parameter int unsigned RUN_DIV      = 25_000_000,
  parameter logic [3:0]  FETCH_STATE  = 4'd1,
  parameter int unsigned STEP_LIMIT   = 16,
  parameter logic [15:0] CYCLE_PRESET = '0
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        StepPulse,
  input  logic [1:0]  Mode,
  input  logic [6:0]  BreakPC,
  input  logic [6:0]  PC_In,
  input  logic [3:0]  State_In,
  output logic        ProcEn,
  output logic        Busy,
  output logic        BreakHit,
  output logic        Timeout,
  output logic [15:0] CycleCount
);

  localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int unsigned LIM_W = $clog2(STEP_LIMIT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [LIM_W-1:0] LIM      = LIM_W'(STEP_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CHECK,
    RUN,
    BREAK
  } state_t;

  state_t             state;
  logic               instr;   // current issue belongs to an instruction-step
  logic [LIM_W-1:0]   count;   // enables issued in this instruction-step
  logic [DIV_W-1:0]   div;
  logic               armed;
  logic               issued;  // ProcEn was high last cycle: PC/state just updated

  // ProcEn is set on the edge that enters the cycle in which it must be high.
  // In RUN, the divider's terminal cycle therefore schedules the pulse for the
  // following cycle, which is RUN_DIV cycles after entry. Dropping Mode[1] in
  // the terminal cycle suppresses the pulse.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      instr      <= 1'b0;
      count      <= '0;
      div        <= '0;
      armed      <= 1'b0;
      issued     <= 1'b0;
      ProcEn     <= 1'b0;
      Busy       <= 1'b0;
      BreakHit   <= 1'b0;
      Timeout    <= 1'b0;
      CycleCount <= CYCLE_PRESET;
    end else begin
      ProcEn <= 1'b0;
      issued <= ProcEn;
      case (state)
        IDLE: begin
          if (Mode[1]) begin
            state <= RUN;
            Busy  <= 1'b1;
            div   <= '0;
            armed <= 1'b0;
          end else if (StepPulse) begin
            state      <= ISSUE;
            Busy       <= 1'b1;
            ProcEn     <= 1'b1;
            CycleCount <= CycleCount + 16'd1;
            Timeout    <= 1'b0;
            instr      <= Mode[0];
            if (Mode[0]) count <= '0;
          end
        end

        ISSUE: begin
          if (instr) begin
            state <= CHECK;
            count <= count + 1'b1;
          end else begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end

        CHECK: begin
          if (State_In == FETCH_STATE) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else if (count == LIM) begin
            state   <= IDLE;
            Busy    <= 1'b0;
            Timeout <= 1'b1;
          end else begin
            state      <= ISSUE;
            ProcEn     <= 1'b1;
            CycleCount <= CycleCount + 16'd1;
          end
        end

        RUN: begin
          if (!Mode[1]) begin
            state <= IDLE;
            Busy  <= 1'b0;
            div   <= '0;
          end else if (Mode[0] && armed && issued &&
                       PC_In == BreakPC && State_In == FETCH_STATE) begin
            // Takes priority over a divider terminal, so no enable follows.
            state    <= BREAK;
            Busy     <= 1'b0;
            BreakHit <= 1'b1;
          end else if (div == DIV_LAST) begin
            div        <= '0;
            ProcEn     <= 1'b1;
            CycleCount <= CycleCount + 16'd1;
            armed      <= 1'b1;
          end else begin
            div <= div + 1'b1;
          end
        end

        BREAK: begin
          if (StepPulse || Mode != 2'b11) begin
            state    <= IDLE;
            BreakHit <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_step_ctrl.sv
module tb_proc_step_ctrl;

  logic        clk = 1'b0;
  logic        Reset;
  logic        StepPulse;
  logic [1:0]  Mode;
  logic [6:0]  BreakPC;
  logic [6:0]  pc;
  logic [3:0]  pst;
  logic        ProcEn, Busy, BreakHit, Timeout;
  logic [15:0] CycleCount;

  // second instance: fast divider and preset counter for the wrap path
  logic [1:0]  Mode2;
  logic        step2 = 1'b0;
  logic [6:0]  zero7 = '0;
  logic [3:0]  zero4 = '0;
  logic        ProcEn2, Busy2, BreakHit2, Timeout2;
  logic [15:0] CycleCount2;

  // processor model controls
  logic        mreset = 1'b0;
  logic [1:0]  pmode = 2'd0;
  logic [3:0]  load_st = 4'd1;
  logic [6:0]  load_pc = '0;
  int          pen_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  proc_step_ctrl #(
    .RUN_DIV(4),
    .FETCH_STATE(4'd1),
    .STEP_LIMIT(16)
  ) dut (
    .clk(clk), .Reset(Reset), .StepPulse(StepPulse), .Mode(Mode),
    .BreakPC(BreakPC), .PC_In(pc), .State_In(pst),
    .ProcEn(ProcEn), .Busy(Busy), .BreakHit(BreakHit), .Timeout(Timeout),
    .CycleCount(CycleCount)
  );

  proc_step_ctrl #(
    .RUN_DIV(2),
    .FETCH_STATE(4'd1),
    .STEP_LIMIT(16),
    .CYCLE_PRESET(16'hFFF0)
  ) dut2 (
    .clk(clk), .Reset(Reset), .StepPulse(step2), .Mode(Mode2),
    .BreakPC(zero7), .PC_In(zero7), .State_In(zero4),
    .ProcEn(ProcEn2), .Busy(Busy2), .BreakHit(BreakHit2), .Timeout(Timeout2),
    .CycleCount(CycleCount2)
  );

  // Processor model, advanced by each enable.
  // pmode 0: states 1->2->3->1, PC++ on 3->1
  // pmode 1: stuck at its loaded state
  // pmode 2: states 1->2->1, PC++ on 2->1
  always @(posedge clk) begin
    if (mreset) begin
      pst     <= load_st;
      pc      <= load_pc;
      pen_cnt <= 0;
    end else if (ProcEn) begin
      pen_cnt <= pen_cnt + 1;
      case (pmode)
        2'd0: if (pst == 4'd3) begin pst <= 4'd1; pc <= pc + 7'd1; end
              else pst <= pst + 4'd1;
        2'd2: if (pst == 4'd2) begin pst <= 4'd1; pc <= pc + 7'd1; end
              else pst <= 4'd2;
        default: pst <= pst;
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_load(input logic [1:0] m, input logic [3:0] st, input logic [6:0] p);
    pmode   = m;
    load_st = st;
    load_pc = p;
    mreset  = 1'b1;
    cyc();
    mreset  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int hits;
    Reset = 1'b1; StepPulse = 1'b0; Mode = 2'b00; Mode2 = 2'b00; BreakPC = 7'h05;
    cyc(); cyc();
    check("rst_procen", 32'(ProcEn), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_breakhit", 32'(BreakHit), 32'd0);
    check("rst_timeout", 32'(Timeout), 32'd0);
    check("rst_count", 32'(CycleCount), 32'd0);
    check("rst_count2_preset", 32'(CycleCount2), 32'hFFF0);
    Reset = 1'b0;
    model_load(2'd0, 4'd1, 7'h00);

    // cycle-step: three strobes, each enable one cycle later
    for (int i = 0; i < 3; i++) begin
      check("cs_idle_procen", 32'(ProcEn), 32'd0);
      StepPulse = 1'b1;
      cyc();
      StepPulse = 1'b0;
      check("cs_procen", 32'(ProcEn), 32'd1);
      check("cs_busy", 32'(Busy), 32'd1);
      cyc();
      check("cs_procen_drop", 32'(ProcEn), 32'd0);
      check("cs_busy_drop", 32'(Busy), 32'd0);
      cyc(); cyc(); cyc();
    end
    check("cs_count", 32'(CycleCount), 32'd3);

    // instruction-step: states 1->2->3->1, three enables, IDLE at n+7
    Mode = 2'b01;
    model_load(2'd0, 4'd1, 7'h00);
    StepPulse = 1'b1;
    cyc();
    StepPulse = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      check("is_procen", 32'(ProcEn), 32'((k % 2 == 1) && k <= 5));
      check("is_busy", 32'(Busy), 32'(k <= 6));
      if (k < 7) cyc();
    end
    check("is_pen_cnt", 32'(pen_cnt), 32'd3);
    check("is_timeout", 32'(Timeout), 32'd0);
    check("is_count", 32'(CycleCount), 32'd6);

    // instruction-step with state stuck: 16 enables then abort at n+33
    model_load(2'd1, 4'd2, 7'h00);
    StepPulse = 1'b1;
    cyc();
    StepPulse = 1'b0;
    c = 1;
    while (Busy && c < 40) begin
      cyc();
      c++;
    end
    check("to_idle_cycle", 32'(c), 32'd33);
    check("to_pen_cnt", 32'(pen_cnt), 32'd16);
    check("to_timeout_set", 32'(Timeout), 32'd1);
    Mode = 2'b00;
    StepPulse = 1'b1;
    cyc();
    StepPulse = 1'b0;
    check("to_timeout_clear", 32'(Timeout), 32'd0);
    check("to_step_procen", 32'(ProcEn), 32'd1);
    cyc();
    check("to_count", 32'(CycleCount), 32'h17);

    // free run: enable every 4th cycle, then leave at a divider terminal
    Mode = 2'b10;
    cyc();
    for (int k = 0; k < 15; k++) begin
      check("run_procen", 32'(ProcEn), 32'(k >= 4 && (k % 4) == 0));
      cyc();
    end
    Mode = 2'b00;
    check("run_term_procen", 32'(ProcEn), 32'd0);
    cyc();
    check("run_exit_procen", 32'(ProcEn), 32'd0);
    check("run_exit_busy", 32'(Busy), 32'd0);
    check("run_count", 32'(CycleCount), 32'h1A);

    // run-to-break: PC 3 at fetch, two states per instruction, break at PC 5
    model_load(2'd2, 4'd1, 7'h03);
    Mode = 2'b11;
    cyc();
    c = 0;
    while (!BreakHit && c < 60) begin
      cyc();
      c++;
    end
    check("bk_cycle", 32'(c), 32'd18);
    check("bk_pc", 32'(pc), 32'h05);
    check("bk_busy", 32'(Busy), 32'd0);
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      if (ProcEn) hits++;
      cyc();
    end
    check("bk_no_procen", 32'(hits), 32'd0);
    check("bk_sticky", 32'(BreakHit), 32'd1);
    StepPulse = 1'b1;
    cyc();
    StepPulse = 1'b0;
    check("bk_clear", 32'(BreakHit), 32'd0);
    check("bk_resume_idle", 32'(Busy), 32'd0);
    hits = 0;
    for (int k = 0; k < 29; k++) begin
      cyc();
      if (BreakHit) hits++;
    end
    check("bk_no_rebreak", 32'(hits), 32'd0);
    check("bk_resume_pc", 32'(pc), 32'h08);
    Mode = 2'b00;
    cyc(); cyc();

    // asynchronous reset in the middle of an enable cycle
    Mode = 2'b10;
    cyc();
    for (int k = 0; k < 4; k++) cyc();
    check("ar_pre_procen", 32'(ProcEn), 32'd1);
    #1 Reset = 1'b1;
    #1;
    check("ar_procen", 32'(ProcEn), 32'd0);
    check("ar_busy", 32'(Busy), 32'd0);
    check("ar_count", 32'(CycleCount), 32'd0);
    check("ar_flags", 32'({BreakHit, Timeout}), 32'd0);
    Mode = 2'b00;
    cyc(); cyc();
    Reset = 1'b0;
    hits = 0;
    for (int k = 0; k < 6; k++) begin
      if (ProcEn || Busy) hits++;
      cyc();
    end
    check("ar_quiet_after", 32'(hits), 32'd0);

    // CycleCount wrap from preset 0xFFF0 after 16 enables
    check("wr_preset", 32'(CycleCount2), 32'hFFF0);
    Mode2 = 2'b10;
    cyc();
    hits = 0;
    c = 0;
    while (CycleCount2 != 16'h0000 && c < 100) begin
      cyc();
      c++;
      if (ProcEn2) hits++;
    end
    check("wr_zero", 32'(CycleCount2), 32'h0000);
    check("wr_pulses", 32'(hits), 32'd16);
    cyc(); cyc();
    check("wr_after", 32'(CycleCount2), 32'h0001);
    Mode2 = 2'b00;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
